pkt_mem_ctrl: RTL and testbench

// Multi-slot packet-buffer controller; parametrised successor to the single-packet write-address/busy controller.

---
 rtl/pkt_mem_pkg.sv | 15 +
 rtl/pkt_mem_if.sv | 35 +++
 rtl/pkt_mem_rd_fsm.sv | 66 ++++++
 rtl/pkt_mem_ctrl.sv | 119 +++++++++++
 tb/tb_pkt_mem_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_mem_pkg.sv
// Shared types and default geometry for the multi-slot packet-buffer controller.
package pkt_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    localparam int AWIDTH_DEF    = 6;
    localparam int SLOT_BITS_DEF = 2;
    localparam int NS            = 2 ** SLOT_BITS_DEF;
    localparam int SD            = 2 ** (AWIDTH_DEF - SLOT_BITS_DEF);
    localparam int OFF_W         = AWIDTH_DEF - SLOT_BITS_DEF;

endpackage

// File: rtl/pkt_mem_if.sv
// Packet source / RAM address / reader bundle seen by the packet-buffer controller.
interface pkt_mem_if #(
    parameter int AWIDTH    = 6,
    parameter int SLOT_BITS = 2
);

    logic                 wr_val_i;
    logic                 wr_eop_i;
    logic                 wr_ready_o;
    logic                 wr_en_o;
    logic [AWIDTH-1:0]    wraddr_o;
    logic                 rd_ready_i;
    logic                 rd_en_o;
    logic [AWIDTH-1:0]    rdaddr_o;
    logic                 rd_val_o;
    logic                 rd_eop_o;
    logic [SLOT_BITS:0]   pkt_cnt_o;
    logic                 busy_o;
    logic                 drop_o;

    modport slave (
        input  wr_val_i, wr_eop_i, rd_ready_i,
        output wr_ready_o, wr_en_o, wraddr_o,
        output rd_en_o, rdaddr_o, rd_val_o, rd_eop_o,
        output pkt_cnt_o, busy_o, drop_o
    );

    modport master (
        output wr_val_i, wr_eop_i, rd_ready_i,
        input  wr_ready_o, wr_en_o, wraddr_o,
        input  rd_en_o, rdaddr_o, rd_val_o, rd_eop_o,
        input  pkt_cnt_o, busy_o, drop_o
    );

endinterface

// File: rtl/pkt_mem_rd_fsm.sv
// Read side: walks stored packets slot by slot and signals when a slot is freed.
module pkt_mem_rd_fsm
    import pkt_mem_pkg::*;
#(
    parameter int SLOT_BITS = 2,
    parameter int OFF_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 clear,
    input  logic                 pkt_avail,
    input  logic                 rd_ready,
    input  logic [OFF_W-1:0]     cur_len,
    output logic                 rd_en,
    output logic                 free,
    output logic [SLOT_BITS-1:0] rd_slot,
    output logic [OFF_W-1:0]     rd_off,
    output logic                 rd_val,
    output logic                 rd_eop
);

    rd_state_t state_q;
    rd_state_t state_d;

    always_ff @(posedge clk_i) begin
        if (clear) begin
            state_q <= IDLE;
            rd_slot <= '0;
            rd_off  <= '0;
            rd_val  <= 1'b0;
            rd_eop  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_val  <= rd_en;
            rd_eop  <= free;
            if (free) begin
                rd_slot <= rd_slot + 1'b1;
                rd_off  <= '0;
            end else if (rd_en) begin
                rd_off <= rd_off + 1'b1;
            end
        end
    end

    // The last word of a packet frees its slot and forces one idle cycle.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        free    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_avail) begin
                    state_d = READ;
                end
            end
            READ: begin
                rd_en = rd_ready;
                if (rd_ready && (rd_off == cur_len)) begin
                    free    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/pkt_mem_ctrl.sv
// Multi-slot packet-buffer controller: write addressing, per-slot length table,
// packet counter and oversize handling around the read FSM.
module pkt_mem_ctrl
    import pkt_mem_pkg::*;
#(
    parameter int AWIDTH        = AWIDTH_DEF,
    parameter int SLOT_BITS     = SLOT_BITS_DEF,
    parameter bit DROP_OVERSIZE = 1'b1
) (
    input  logic       clk_i,
    input  logic       srst_n_i,
    input  logic       clr_i,
    pkt_mem_if.slave   bus
);

    localparam int                 OFFW     = AWIDTH - SLOT_BITS;
    localparam int                 SLOTS    = 2 ** SLOT_BITS;
    localparam logic [OFFW-1:0]    LAST_OFF = {OFFW{1'b1}};
    localparam logic [SLOT_BITS:0] FULL     = (SLOT_BITS + 1)'(SLOTS);

    logic                 clear;
    logic [SLOT_BITS-1:0] wr_slot;
    logic [OFFW-1:0]      wr_off;
    logic [OFFW-1:0]      len_q [SLOTS];
    logic [SLOT_BITS:0]   cnt;
    logic                 dropping;
    logic                 truncating;
    logic                 drop_q;

    logic                 wr_ready;
    logic                 accept;
    logic                 wr_en;
    logic                 commit;
    logic                 drop_end;
    logic                 overflow;

    logic                 rd_en;
    logic                 free;
    logic [SLOT_BITS-1:0] rd_slot;
    logic [OFFW-1:0]      rd_off;
    logic                 rd_val;
    logic                 rd_eop;

    assign clear    = !srst_n_i || clr_i;
    assign wr_ready = (cnt != FULL) || dropping;
    assign accept   = bus.wr_val_i && wr_ready;
    // Once a packet overflows its slot, further words must not overwrite the last word.
    assign wr_en    = accept && !dropping && !truncating;
    assign commit   = accept && bus.wr_eop_i && !dropping;
    assign drop_end = accept && bus.wr_eop_i && dropping;
    assign overflow = wr_en && !bus.wr_eop_i && (wr_off == LAST_OFF);

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_slot    <= '0;
            wr_off     <= '0;
            cnt        <= '0;
            dropping   <= 1'b0;
            truncating <= 1'b0;
            drop_q     <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            drop_q <= drop_end;
            if (commit) begin
                len_q[wr_slot] <= truncating ? LAST_OFF : wr_off;
                wr_slot        <= wr_slot + 1'b1;
                wr_off         <= '0;
                truncating     <= 1'b0;
            end else if (drop_end) begin
                dropping <= 1'b0;
                wr_off   <= '0;
            end else if (overflow) begin
                if (DROP_OVERSIZE) begin
                    dropping <= 1'b1;
                end else begin
                    truncating <= 1'b1;
                end
            end else if (wr_en) begin
                wr_off <= wr_off + 1'b1;
            end
            if (commit && !free) begin
                cnt <= cnt + 1'b1;
            end else if (free && !commit) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    pkt_mem_rd_fsm #(
        .SLOT_BITS (SLOT_BITS),
        .OFF_W     (OFFW)
    ) u_rd_fsm (
        .clk_i     (clk_i),
        .clear     (clear),
        .pkt_avail (cnt != '0),
        .rd_ready  (bus.rd_ready_i),
        .cur_len   (len_q[rd_slot]),
        .rd_en     (rd_en),
        .free      (free),
        .rd_slot   (rd_slot),
        .rd_off    (rd_off),
        .rd_val    (rd_val),
        .rd_eop    (rd_eop)
    );

    assign bus.wr_ready_o = wr_ready;
    assign bus.wr_en_o    = wr_en;
    assign bus.wraddr_o   = {wr_slot, wr_off};
    assign bus.rd_en_o    = rd_en;
    assign bus.rdaddr_o   = {rd_slot, rd_off};
    assign bus.rd_val_o   = rd_val;
    assign bus.rd_eop_o   = rd_eop;
    assign bus.pkt_cnt_o  = cnt;
    assign bus.busy_o     = (cnt == FULL);
    assign bus.drop_o     = drop_q;

endmodule

// File: tb/tb_pkt_mem_ctrl.sv
// Scoreboard bench for pkt_mem_ctrl: a dropping and a truncating instance share one stimulus.
`timescale 1ns/1ps
module tb_pkt_mem_ctrl;
    import pkt_mem_pkg::*;

    localparam int AW = 6;
    localparam int SB = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } rd_item_t;

    logic clk      = 1'b0;
    logic srst_n   = 1'b0;
    logic clr      = 1'b0;
    logic wr_val   = 1'b0;
    logic wr_eop   = 1'b0;
    logic rd_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_q [$];
    rd_item_t      rd_q [$];
    logic          eop_q [$];
    int            wslot = 0;

    int            a_wr_cnt = 0;
    int            a_rd_val_cnt = 0;
    int            a_drop_cnt = 0;
    int            b_wr_cnt = 0;
    int            b_rd_val_cnt = 0;
    int            b_eop_cnt = 0;
    logic [AW-1:0] b_last_rdaddr = '0;
    logic [AW-1:0] b_eop_addr = '0;

    always #5 clk = ~clk;

    pkt_mem_if #(.AWIDTH(AW), .SLOT_BITS(SB)) a_if ();
    pkt_mem_if #(.AWIDTH(AW), .SLOT_BITS(SB)) b_if ();

    assign a_if.wr_val_i   = wr_val;
    assign a_if.wr_eop_i   = wr_eop;
    assign a_if.rd_ready_i = rd_ready;
    assign b_if.wr_val_i   = wr_val;
    assign b_if.wr_eop_i   = wr_eop;
    assign b_if.rd_ready_i = rd_ready;

    pkt_mem_ctrl #(.AWIDTH(AW), .SLOT_BITS(SB), .DROP_OVERSIZE(1'b1)) dut_drop (
        .clk_i    (clk),
        .srst_n_i (srst_n),
        .clr_i    (clr),
        .bus      (a_if.slave)
    );

    pkt_mem_ctrl #(.AWIDTH(AW), .SLOT_BITS(SB), .DROP_OVERSIZE(1'b0)) dut_trunc (
        .clk_i    (clk),
        .srst_n_i (srst_n),
        .clr_i    (clr),
        .bus      (b_if.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        rd_item_t it;
        if (a_if.wr_en_o) begin
            a_wr_cnt++;
            if (wr_q.size() == 0) checkOutput("wr_unexpected", {31'b0, a_if.wr_en_o}, 0);
            else checkOutput("wraddr", {26'b0, a_if.wraddr_o}, {26'b0, wr_q.pop_front()});
        end
        if (a_if.rd_val_o) begin
            a_rd_val_cnt++;
            if (eop_q.size() == 0) checkOutput("rd_val_unexpected", {31'b0, a_if.rd_val_o}, 0);
            else checkOutput("rd_eop", {31'b0, a_if.rd_eop_o}, {31'b0, eop_q.pop_front()});
        end
        if (a_if.rd_en_o) begin
            if (rd_q.size() == 0) begin
                checkOutput("rd_unexpected", {31'b0, a_if.rd_en_o}, 0);
            end else begin
                it = rd_q.pop_front();
                checkOutput("rdaddr", {26'b0, a_if.rdaddr_o}, {26'b0, it.addr});
                eop_q.push_back(it.last);
            end
        end
        if (a_if.drop_o) a_drop_cnt++;
        if (b_if.wr_en_o) b_wr_cnt++;
        if (b_if.rd_val_o) begin
            b_rd_val_cnt++;
            if (b_if.rd_eop_o) begin
                b_eop_cnt++;
                b_eop_addr = b_last_rdaddr;
            end
        end
        if (b_if.rd_en_o) b_last_rdaddr = b_if.rdaddr_o;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flushModel();
        wr_q.delete();
        rd_q.delete();
        eop_q.delete();
        wslot = 0;
    endtask

    // Drives one packet of n words, pushing the expected write and read traffic first.
    task automatic applyStimulus(input int n);
        int  nw;
        bit  acc;
        int  guard;
        nw = (n > SD) ? SD : n;
        for (int i = 0; i < nw; i++) wr_q.push_back(AW'(wslot * SD + i));
        if (n <= SD) begin
            for (int i = 0; i < n; i++) rd_q.push_back('{addr: AW'(wslot * SD + i), last: (i == n - 1)});
            wslot = (wslot + 1) % NS;
        end
        for (int i = 0; i < n; i++) begin
            wr_val = 1'b1;
            wr_eop = (i == n - 1);
            acc    = 1'b0;
            guard  = 0;
            while (!acc) begin
                @(negedge clk);
                acc = a_if.wr_ready_o;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 300) begin
                    checkOutput("wr_ready_timeout", {31'b0, a_if.wr_ready_o}, 1);
                    acc = 1'b1;
                end
            end
        end
        wr_val = 1'b0;
        wr_eop = 1'b0;
    endtask

    task automatic waitCount(input bit use_b, input int target, input string tag);
        int g;
        for (g = 0; g < 1000; g++) begin
            if (use_b ? (int'(b_if.pkt_cnt_o) == target) : (int'(a_if.pkt_cnt_o) == target)) break;
            @(posedge clk);
            #1;
        end
        if (g == 1000) checkOutput(tag, use_b ? {29'b0, b_if.pkt_cnt_o} : {29'b0, a_if.pkt_cnt_o}, target);
    endtask

    task automatic checkCleared(input string pfx);
        checkOutput({pfx, "_pkt_cnt"}, {29'b0, a_if.pkt_cnt_o}, 0);
        checkOutput({pfx, "_wraddr"}, {26'b0, a_if.wraddr_o}, 0);
        checkOutput({pfx, "_rdaddr"}, {26'b0, a_if.rdaddr_o}, 0);
        checkOutput({pfx, "_rd_val"}, {31'b0, a_if.rd_val_o}, 0);
        checkOutput({pfx, "_busy"}, {31'b0, a_if.busy_o}, 0);
        checkOutput({pfx, "_drop"}, {31'b0, a_if.drop_o}, 0);
        checkOutput({pfx, "_b_pkt_cnt"}, {29'b0, b_if.pkt_cnt_o}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int            base_a;
        int            base_b;
        int            base_d;
        int            base_v;
        int            base_e;
        logic [AW-1:0] exp_last;
        logic [3:0]    pat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkCleared("rst");
        checkOutput("rst_wr_ready", {31'b0, a_if.wr_ready_o}, 1);
        @(posedge clk);
        #1;
        srst_n = 1'b1;

        // 3-word packet held, then read out
        base_a = a_wr_cnt;
        applyStimulus(3);
        waitCycles(2);
        checkOutput("t1_pkt_cnt", {29'b0, a_if.pkt_cnt_o}, 1);
        checkOutput("t1_wr_cnt", a_wr_cnt - base_a, 3);
        base_v = a_rd_val_cnt;
        rd_ready = 1'b1;
        waitCount(1'b0, 0, "t1_drain_timeout");
        waitCycles(2);
        checkOutput("t1_rd_val_cnt", a_rd_val_cnt - base_v, 3);
        rd_ready = 1'b0;

        // Fill all slots, then drain one and wrap the write pointer
        clr = 1'b1;
        waitCycles(1);
        clr = 1'b0;
        flushModel();
        repeat (4) applyStimulus(2);
        @(negedge clk);
        checkOutput("t2_full_cnt", {29'b0, a_if.pkt_cnt_o}, NS);
        checkOutput("t2_busy", {31'b0, a_if.busy_o}, 1);
        checkOutput("t2_wr_ready", {31'b0, a_if.wr_ready_o}, 0);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        waitCount(1'b0, NS - 1, "t2_drain_one_timeout");
        rd_ready = 1'b0;
        @(negedge clk);
        checkOutput("t2_busy_after", {31'b0, a_if.busy_o}, 0);
        checkOutput("t2_wr_ready_after", {31'b0, a_if.wr_ready_o}, 1);
        @(posedge clk);
        #1;
        applyStimulus(2);
        waitCycles(1);
        checkOutput("t2_refill_cnt", {29'b0, a_if.pkt_cnt_o}, NS);
        rd_ready = 1'b1;
        waitCount(1'b0, 0, "t2_drain_timeout");
        rd_ready = 1'b0;
        waitCycles(3);

        // Oversize packet: dropped by one instance, truncated by the other
        base_a = a_wr_cnt;
        base_b = b_wr_cnt;
        base_d = a_drop_cnt;
        exp_last = AW'(wslot * SD + SD - 1);
        applyStimulus(20);
        waitCycles(2);
        checkOutput("t3_drop_wr_cnt", a_wr_cnt - base_a, SD);
        checkOutput("t3_drop_pulse", a_drop_cnt - base_d, 1);
        checkOutput("t3_drop_pkt_cnt", {29'b0, a_if.pkt_cnt_o}, 0);
        checkOutput("t3_trunc_wr_cnt", b_wr_cnt - base_b, SD);
        checkOutput("t3_trunc_pkt_cnt", {29'b0, b_if.pkt_cnt_o}, 1);
        base_v = b_rd_val_cnt;
        base_e = b_eop_cnt;
        rd_ready = 1'b1;
        waitCount(1'b1, 0, "t3_trunc_drain_timeout");
        waitCycles(2);
        checkOutput("t3_trunc_rd_val_cnt", b_rd_val_cnt - base_v, SD);
        checkOutput("t3_trunc_eop_cnt", b_eop_cnt - base_e, 1);
        checkOutput("t3_trunc_eop_addr", {26'b0, b_eop_addr}, {26'b0, exp_last});
        applyStimulus(2);
        waitCount(1'b0, 0, "t3_next_drain_timeout");
        waitCount(1'b1, 0, "t3_next_b_drain_timeout");
        rd_ready = 1'b0;
        waitCycles(3);

        // Commit and free on the same clock edge
        applyStimulus(2);
        applyStimulus(2);
        waitCycles(2);
        checkOutput("t4_pre_cnt", {29'b0, a_if.pkt_cnt_o}, 2);
        fork
            applyStimulus(3);
            begin
                @(posedge clk);
                #1;
                rd_ready = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                rd_ready = 1'b0;
            end
        join
        @(negedge clk);
        checkOutput("t4_same_cycle_cnt", {29'b0, a_if.pkt_cnt_o}, 2);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        waitCount(1'b0, 0, "t4_drain_timeout");
        rd_ready = 1'b0;
        waitCycles(3);

        // Reader back-pressure pattern 1,0,0,1
        applyStimulus(4);
        waitCycles(3);
        base_v = a_rd_val_cnt;
        pat = 4'b1001;
        for (int k = 0; k < 60; k++) begin
            if (a_if.pkt_cnt_o == 0) break;
            rd_ready = pat[k % 4];
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        waitCycles(2);
        checkOutput("t5_rd_val_cnt", a_rd_val_cnt - base_v, 4);
        checkOutput("t5_pkt_cnt", {29'b0, a_if.pkt_cnt_o}, 0);

        // Reset in the middle of a packet write
        wr_q.push_back(AW'(wslot * SD));
        wr_q.push_back(AW'(wslot * SD + 1));
        wr_val = 1'b1;
        wr_eop = 1'b0;
        waitCycles(2);
        wr_val = 1'b0;
        srst_n = 1'b0;
        waitCycles(1);
        @(negedge clk);
        checkCleared("srst");
        checkOutput("srst_wr_en", {31'b0, a_if.wr_en_o}, 0);
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        flushModel();
        applyStimulus(3);
        rd_ready = 1'b1;
        waitCount(1'b0, 0, "t6_drain_timeout");
        rd_ready = 1'b0;
        waitCycles(3);

        // Clear in the middle of a packet read
        applyStimulus(4);
        waitCycles(3);
        rd_ready = 1'b1;
        waitCycles(2);
        rd_ready = 1'b0;
        clr = 1'b1;
        waitCycles(1);
        clr = 1'b0;
        @(negedge clk);
        checkCleared("clr");
        @(posedge clk);
        #1;
        flushModel();
        applyStimulus(2);
        rd_ready = 1'b1;
        waitCount(1'b0, 0, "t7_drain_timeout");
        waitCycles(3);
        checkOutput("t7_sb_pending", rd_q.size() + eop_q.size() + wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
